param_step_processor: RTL

- Parametrised successor to the 4-bit single-step processor.
- Data width and register count are generic. Adds a debounced step button, a free-running run mode, an extended ALU with Zero/Carry flags, a Busy indicator and a retired-instruction counter.
- Instructions come from the external OpCode switches.
- The block sits at board top level between the switches/button and the StoreLights LEDs.

---
 rtl/proc_pkg.sv | 44 ++++
 rtl/step_button_conditioner.sv | 50 +++++
 rtl/param_step_processor.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - opcodes, ALU selects, FSM encoding and instruction field helpers
package proc_pkg;

    localparam logic [1:0] OP_LDI = 2'b00;
    localparam logic [1:0] OP_STR = 2'b01;
    localparam logic [1:0] OP_MOV = 2'b10;
    localparam logic [1:0] OP_ALU = 2'b11;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SHL = 3'd5;
    localparam logic [2:0] ALU_SHR = 3'd6;
    localparam logic [2:0] ALU_NOT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Instruction words are zero-extended to this width so the helpers can
    // serve any DATA_W/REG_AW combination; callers cast the result down.
    localparam int MAX_INSTR_W = 64;
    typedef logic [MAX_INSTR_W-1:0] instr_word_t;

    function automatic logic [1:0] instr_op(input instr_word_t instr, input int instr_w);
        instr_word_t t;
        t = instr >> (instr_w - 2);
        return t[1:0];
    endfunction

    function automatic instr_word_t instr_rx(input instr_word_t instr, input int data_w,
                                             input int reg_aw);
        return (instr >> data_w) & ((64'd1 << reg_aw) - 64'd1);
    endfunction

    function automatic instr_word_t instr_pl(input instr_word_t instr, input int data_w);
        return instr & ((64'd1 << data_w) - 64'd1);
    endfunction

endpackage

// File: rtl/step_button_conditioner.sv
// rtl/step_button_conditioner.sv - synchronise and debounce the step button into a press pulse
// Ports:
//   Clock        in   system clock
//   Reset        in   async active-low reset
//   button_n_i   in   raw button, active-low, idles high
//   step_pulse_o out  one-cycle pulse when the accepted level falls
module step_button_conditioner #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic button_n_i,
    output logic step_pulse_o
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          pulse_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= button_n_i;
            sync2_q <= sync1_q;
            pulse_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                // This is the DEBOUNCE_CYC-th differing sample in a row.
                level_q <= sync2_q;
                cnt_q   <= '0;
                pulse_q <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign step_pulse_o = pulse_q;

endmodule

// File: rtl/param_step_processor.sv
// rtl/param_step_processor.sv - switch-programmed step processor with ALU flags and run mode
// Ports:
//   Clock, Reset         system clock, async active-low reset
//   SingleStep           1 = step on button press, 0 = trigger every RUN_PERIOD clocks
//   ButtonForSingleStep  raw step button, active-low
//   OpCode               instruction word {op, rx, payload}
//   StoreLights          value written by the last STR
//   Busy, Zero, Carry    in-flight indicator and ALU flags
//   InstrCount           retired instruction count, wraps
module param_step_processor
    import proc_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int REG_AW       = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int RUN_PERIOD   = 8,
    parameter int CNT_W        = 8
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       SingleStep,
    input  logic                       ButtonForSingleStep,
    input  logic [2+REG_AW+DATA_W-1:0] OpCode,
    output logic [DATA_W-1:0]          StoreLights,
    output logic                       Busy,
    output logic                       Zero,
    output logic                       Carry,
    output logic [CNT_W-1:0]           InstrCount
);

    localparam int INSTR_W  = 2 + REG_AW + DATA_W;
    localparam int NUM_REGS = 1 << REG_AW;
    localparam int RUN_W    = $clog2(RUN_PERIOD);

    state_e              state_q;
    logic                busy_q;
    logic [INSTR_W-1:0]  ir_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   result_q;
    logic                zero_stage_q;
    logic                carry_stage_q;
    logic [DATA_W-1:0]   store_q;
    logic                zero_q;
    logic                carry_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [RUN_W-1:0]    run_cnt_q;

    logic                step_pulse;
    logic                trigger;
    logic [1:0]          op;
    logic [REG_AW-1:0]   rx;
    logic [DATA_W-1:0]   pl;
    logic [DATA_W-1:0]   opnd_a;
    logic [DATA_W-1:0]   opnd_b;
    logic [DATA_W:0]     alu_wide;
    logic [DATA_W-1:0]   result_d;
    logic                zero_d;
    logic                carry_d;

    step_button_conditioner #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_button (
        .Clock       (Clock),
        .Reset       (Reset),
        .button_n_i  (ButtonForSingleStep),
        .step_pulse_o(step_pulse)
    );

    // Run counter sits at 0 in single-step mode, so the first run-mode
    // trigger comes a full RUN_PERIOD after the mode switch.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            run_cnt_q <= '0;
        end else if (SingleStep || run_cnt_q == RUN_W'(RUN_PERIOD - 1)) begin
            run_cnt_q <= '0;
        end else begin
            run_cnt_q <= run_cnt_q + RUN_W'(1);
        end
    end

    assign trigger = SingleStep ? step_pulse : (run_cnt_q == RUN_W'(RUN_PERIOD - 1));

    assign op = instr_op({{(MAX_INSTR_W-INSTR_W){1'b0}}, ir_q}, INSTR_W);
    assign rx = REG_AW'(instr_rx({{(MAX_INSTR_W-INSTR_W){1'b0}}, ir_q}, DATA_W, REG_AW));
    assign pl = DATA_W'(instr_pl({{(MAX_INSTR_W-INSTR_W){1'b0}}, ir_q}, DATA_W));

    // Carry lives in alu_wide[DATA_W]; SUB borrow falls out of the wrap.
    always_comb begin
        opnd_a   = regs_q[rx];
        opnd_b   = regs_q[pl[REG_AW+2:3]];
        alu_wide = '0;
        case (pl[2:0])
            ALU_ADD: alu_wide = {1'b0, opnd_a} + {1'b0, opnd_b};
            ALU_SUB: alu_wide = {1'b0, opnd_a} - {1'b0, opnd_b};
            ALU_AND: alu_wide = {1'b0, opnd_a & opnd_b};
            ALU_OR:  alu_wide = {1'b0, opnd_a | opnd_b};
            ALU_XOR: alu_wide = {1'b0, opnd_a ^ opnd_b};
            ALU_SHL: alu_wide = {opnd_a, 1'b0};
            ALU_SHR: alu_wide = {opnd_a[0], 1'b0, opnd_a[DATA_W-1:1]};
            default: alu_wide = {1'b0, ~opnd_a};
        endcase
        zero_d  = (alu_wide[DATA_W-1:0] == '0);
        carry_d = alu_wide[DATA_W];
        case (op)
            OP_LDI:  result_d = pl;
            OP_STR:  result_d = opnd_a;
            OP_MOV:  result_d = regs_q[pl[REG_AW-1:0]];
            default: result_d = alu_wide[DATA_W-1:0];
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            busy_q        <= 1'b0;
            ir_q          <= '0;
            result_q      <= '0;
            zero_stage_q  <= 1'b0;
            carry_stage_q <= 1'b0;
            store_q       <= '0;
            zero_q        <= 1'b0;
            carry_q       <= 1'b0;
            cnt_q         <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        ir_q    <= OpCode;
                        state_q <= ST_EXEC;
                        busy_q  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    result_q      <= result_d;
                    zero_stage_q  <= zero_d;
                    carry_stage_q <= carry_d;
                    state_q       <= ST_WB;
                end
                ST_WB: begin
                    if (op == OP_STR) begin
                        store_q <= result_q;
                    end else begin
                        regs_q[rx] <= result_q;
                    end
                    if (op == OP_ALU) begin
                        zero_q  <= zero_stage_q;
                        carry_q <= carry_stage_q;
                    end
                    cnt_q   <= cnt_q + CNT_W'(1);
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign StoreLights = store_q;
    assign Busy        = busy_q;
    assign Zero        = zero_q;
    assign Carry       = carry_q;
    assign InstrCount  = cnt_q;

endmodule
